// File: rtl/cla_sub_pipe_32_if.sv
// Operand/result bundle for cla_sub_pipe_32: producer-side valid/ready with
// operands, consumer-side valid/ready with the difference and its flags.
interface cla_sub_pipe_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  // Environment side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/cla_sub_pipe_32.sv
// Two-stage pipelined subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin. The low half resolves in stage 1 and the high half in
// stage 2, using the registered mid carry as its carry-in.
module cla_sub_pipe_32 #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_sub_pipe_32_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  // Carry-lookahead add of one half; returns {carry_out, sum}.
  function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int i = 0; i < HALF; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  // Stage 1 registers. The operand MSBs needed for overflow are the top
  // bits of s1_a_hi / s1_b_hi, so they are not stored separately.
  logic            s1_valid;
  logic [HALF-1:0] s1_diff_lo;
  logic            s1_c_mid;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;

  // Stage 2 (output) registers.
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;

  logic            s2_ready;
  logic            in_ready;
  logic            accept;
  logic            advance;
  logic [HALF:0]   lo_sum;
  logic [HALF:0]   hi_sum;
  logic [WIDTH-1:0] diff_full;

  assign s2_ready  = !out_valid_q || bus.out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign accept    = bus.in_valid && in_ready;
  assign advance   = s1_valid && s2_ready;

  assign lo_sum    = cla_add(bus.a[HALF-1:0], ~bus.b[HALF-1:0], ~bus.bin);
  assign hi_sum    = cla_add(s1_a_hi, ~s1_b_hi, s1_c_mid);
  assign diff_full = {hi_sum[HALF-1:0], s1_diff_lo};

  // Stage 1: capture low-half result and upper operands on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_c_mid   <= 1'b0;
      s1_a_hi    <= '0;
      s1_b_hi    <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_diff_lo <= lo_sum[HALF-1:0];
      s1_c_mid   <= lo_sum[HALF];
      s1_a_hi    <= bus.a[WIDTH-1:HALF];
      s1_b_hi    <= bus.b[WIDTH-1:HALF];
    end else if (advance) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2: finish the high half and register the result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      diff_q      <= diff_full;
      bout_q      <= ~hi_sum[HALF];
      ovf_q       <= (s1_a_hi[HALF-1] != s1_b_hi[HALF-1]) &&
                     (hi_sum[HALF-1] != s1_a_hi[HALF-1]);
      zero_q      <= (diff_full == '0);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
